// File: rtl/alu_sequencer.sv
// Issue/collect front end for the combinational ALU.
// It drives the ALU operands from registers and captures the ALU result into a
// held response. SLL/SRL are executed locally, one bit per cycle.
module alu_sequencer #(
  parameter int unsigned W_CPU    = 32,
  parameter int unsigned W_OPCODE = 4,
  parameter int unsigned W_SHAMT  = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [W_OPCODE-1:0] req_op,
  input  logic [W_CPU-1:0]    req_a,
  input  logic [W_CPU-1:0]    req_b,
  input  logic [W_SHAMT-1:0]  req_shamt,
  output logic [W_OPCODE-1:0] alu_op,
  output logic [W_CPU-1:0]    alu_a,
  output logic [W_CPU-1:0]    alu_b,
  input  logic [W_CPU-1:0]    alu_r,
  input  logic                alu_overflow,
  input  logic                alu_zero,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [W_CPU-1:0]    rsp_r,
  output logic                rsp_overflow,
  output logic                rsp_zero,
  output logic                rsp_err
);

  // Opcode encodings shared with the ALU
  localparam logic [W_OPCODE-1:0] OP_ADD  = W_OPCODE'(0);
  localparam logic [W_OPCODE-1:0] OP_SUB  = W_OPCODE'(1);
  localparam logic [W_OPCODE-1:0] OP_SLT  = W_OPCODE'(2);
  localparam logic [W_OPCODE-1:0] OP_SLL  = W_OPCODE'(3);
  localparam logic [W_OPCODE-1:0] OP_SRL  = W_OPCODE'(4);
  localparam logic [W_OPCODE-1:0] OP_AND  = W_OPCODE'(5);
  localparam logic [W_OPCODE-1:0] OP_NAND = W_OPCODE'(6);
  localparam logic [W_OPCODE-1:0] OP_OR   = W_OPCODE'(7);
  localparam logic [W_OPCODE-1:0] OP_NOR  = W_OPCODE'(8);
  localparam logic [W_OPCODE-1:0] OP_XOR  = W_OPCODE'(9);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EXEC  = 2'd1,
    S_SHIFT = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic                 shl_q, shl_d;
  logic [W_SHAMT-1:0]   cnt_q, cnt_d;
  logic [W_CPU-1:0]     acc_q, acc_d;
  logic [W_OPCODE-1:0]  alu_op_d;
  logic [W_CPU-1:0]     alu_a_d, alu_b_d;
  logic [W_CPU-1:0]     rsp_r_d;
  logic                 rsp_overflow_d, rsp_zero_d, rsp_err_d;
  logic                 op_legal_c, op_shift_c;

  // Classify the incoming opcode
  always_comb begin
    op_legal_c = 1'b0;
    op_shift_c = 1'b0;
    case (req_op)
      OP_ADD, OP_SUB, OP_SLT, OP_AND, OP_NAND,
      OP_OR, OP_NOR, OP_XOR: op_legal_c = 1'b1;
      OP_SLL, OP_SRL: begin
        op_legal_c = 1'b1;
        op_shift_c = 1'b1;
      end
      default: op_legal_c = 1'b0;
    endcase
  end

  // Next-state and datapath updates
  always_comb begin
    state_d        = state_q;
    shl_d          = shl_q;
    cnt_d          = cnt_q;
    acc_d          = acc_q;
    alu_op_d       = alu_op;
    alu_a_d        = alu_a;
    alu_b_d        = alu_b;
    rsp_r_d        = rsp_r;
    rsp_overflow_d = rsp_overflow;
    rsp_zero_d     = rsp_zero;
    rsp_err_d      = rsp_err;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (!op_legal_c) begin
            // Unsupported opcode: answer immediately, the ALU is left untouched
            state_d        = S_HOLD;
            rsp_r_d        = '0;
            rsp_overflow_d = 1'b0;
            rsp_zero_d     = 1'b1;
            rsp_err_d      = 1'b1;
          end else if (op_shift_c) begin
            state_d = S_SHIFT;
            acc_d   = req_a;
            cnt_d   = req_shamt;
            shl_d   = (req_op == OP_SLL);
          end else begin
            state_d  = S_EXEC;
            alu_op_d = req_op;
            alu_a_d  = req_a;
            alu_b_d  = req_b;
          end
        end
      end
      S_EXEC: begin
        state_d        = S_HOLD;
        rsp_r_d        = alu_r;
        rsp_overflow_d = alu_overflow;
        rsp_zero_d     = alu_zero;
        rsp_err_d      = 1'b0;
      end
      S_SHIFT: begin
        if (cnt_q != '0) begin
          acc_d = shl_q ? (acc_q << 1) : (acc_q >> 1);
          cnt_d = cnt_q - W_SHAMT'(1);
        end else begin
          state_d        = S_HOLD;
          rsp_r_d        = acc_q;
          rsp_overflow_d = 1'b0;
          rsp_zero_d     = (acc_q == '0);
          rsp_err_d      = 1'b0;
        end
      end
      S_HOLD: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, datapath and handshake registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      shl_q        <= 1'b0;
      cnt_q        <= '0;
      acc_q        <= '0;
      alu_op       <= '0;
      alu_a        <= '0;
      alu_b        <= '0;
      rsp_r        <= '0;
      rsp_overflow <= 1'b0;
      rsp_zero     <= 1'b0;
      rsp_err      <= 1'b0;
      rsp_valid    <= 1'b0;
      req_ready    <= 1'b1;
    end else begin
      state_q      <= state_d;
      shl_q        <= shl_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      alu_op       <= alu_op_d;
      alu_a        <= alu_a_d;
      alu_b        <= alu_b_d;
      rsp_r        <= rsp_r_d;
      rsp_overflow <= rsp_overflow_d;
      rsp_zero     <= rsp_zero_d;
      rsp_err      <= rsp_err_d;
      rsp_valid    <= (state_d == S_HOLD);
      req_ready    <= (state_d == S_IDLE);
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: behavioural ALU plus table, corner and random tests.
module tb_alu_sequencer;
  localparam int unsigned W_CPU    = 32;
  localparam int unsigned W_OPCODE = 4;
  localparam int unsigned W_SHAMT  = 5;

  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, SLT = 4'd2, SLL = 4'd3, SRL = 4'd4;
  localparam logic [3:0] AND_ = 4'd5, NAND = 4'd6, OR_ = 4'd7, NOR = 4'd8, XOR_ = 4'd9;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_valid, req_ready, rsp_valid, rsp_ready;
  logic [W_OPCODE-1:0] req_op, alu_op;
  logic [W_CPU-1:0] req_a, req_b, alu_a, alu_b, alu_r, rsp_r;
  logic [W_SHAMT-1:0] req_shamt;
  logic alu_overflow, alu_zero, rsp_overflow, rsp_zero, rsp_err;

  int n_vec = 0;
  int n_err = 0;

  // Last operands the ALU is expected to be holding
  logic [3:0]  m_op = '0;
  logic [31:0] m_a = '0, m_b = '0;

  always #5 clk = ~clk;

  alu_sequencer #(.W_CPU(W_CPU), .W_OPCODE(W_OPCODE), .W_SHAMT(W_SHAMT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_shamt(req_shamt),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_r(alu_r), .alu_overflow(alu_overflow), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_r(rsp_r),
    .rsp_overflow(rsp_overflow), .rsp_zero(rsp_zero), .rsp_err(rsp_err)
  );

  // Behavioural combinational ALU: {overflow, zero, r}
  function automatic logic [33:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic v;
    r = '0;
    v = 1'b0;
    case (op)
      ADD:  begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
      SUB:  begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
      SLT:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      SLL:  r = a << b[4:0];
      SRL:  r = a >> b[4:0];
      AND_: r = a & b;
      NAND: r = ~(a & b);
      OR_:  r = a | b;
      NOR:  r = ~(a | b);
      XOR_: r = a ^ b;
      default: r = '0;
    endcase
    return {v, (r == 32'd0), r};
  endfunction

  assign {alu_overflow, alu_zero, alu_r} = alu_fn(alu_op, alu_a, alu_b);

  function automatic bit is_legal(input logic [3:0] op);
    return op <= 4'd9;
  endfunction

  function automatic bit is_shift(input logic [3:0] op);
    return (op == SLL) || (op == SRL);
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Issue one request, collect its response with rsp_ready=1, and check it
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh, input logic [31:0] er, input logic eo, input logic ez,
                        input logic ee, input int elat);
    int t;
    int k;
    @(negedge clk);
    req_op = op; req_a = a; req_b = b; req_shamt = sh; req_valid = 1'b1;
    t = 0;
    while (!req_ready && t < 50) begin @(negedge clk); t++; end
    chk({tag, ".req_ready"}, 64'(req_ready), 64'(1));
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    if (is_legal(op) && !is_shift(op)) begin m_op = op; m_a = a; m_b = b; end
    chk({tag, ".alu_op"}, 64'(alu_op), 64'(m_op));
    chk({tag, ".alu_a"}, 64'(alu_a), 64'(m_a));
    chk({tag, ".alu_b"}, 64'(alu_b), 64'(m_b));
    k = 0;
    while (!rsp_valid && k < 100) begin @(negedge clk); k++; end
    chk({tag, ".rsp_valid"}, 64'(rsp_valid), 64'(1));
    if (elat >= 0) chk({tag, ".latency"}, 64'(k), 64'(elat));
    chk({tag, ".rsp_r"}, 64'(rsp_r), 64'(er));
    chk({tag, ".rsp_overflow"}, 64'(rsp_overflow), 64'(eo));
    chk({tag, ".rsp_zero"}, 64'(rsp_zero), 64'(ez));
    chk({tag, ".rsp_err"}, 64'(rsp_err), 64'(ee));
    @(negedge clk);
    chk({tag, ".idle_valid"}, 64'(rsp_valid), 64'(0));
    chk({tag, ".idle_ready"}, 64'(req_ready), 64'(1));
  endtask

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [31:0] r;
    logic        ovf;
    logic        zero;
    logic        err;
    int          lat;
  } vec_t;

  vec_t tbl[14];

  initial begin
    logic [31:0] held_r;
    logic [3:0]  rop;
    logic [31:0] ra, rb, er;
    logic [4:0]  rsh;
    logic        eo, ez, ee;
    logic [33:0] f;
    int          elat;
    int          seen;

    tbl[0]  = '{"add_5_7",   ADD,  32'd5,        32'd7,        5'd0,  32'd12,       1'b0, 1'b0, 1'b0, 1};
    tbl[1]  = '{"and_zero",  AND_, 32'hF0F00000, 32'h0F0F0000, 5'd0,  32'h0,        1'b0, 1'b1, 1'b0, 1};
    tbl[2]  = '{"xor",       XOR_, 32'hFFFFFFFF, 32'h0000FFFF, 5'd0,  32'hFFFF0000, 1'b0, 1'b0, 1'b0, 1};
    tbl[3]  = '{"sll_31",    SLL,  32'h1,        32'h0,        5'd31, 32'h80000000, 1'b0, 1'b0, 1'b0, 32};
    tbl[4]  = '{"srl_4",     SRL,  32'h80000000, 32'h0,        5'd4,  32'h08000000, 1'b0, 1'b0, 1'b0, 5};
    tbl[5]  = '{"srl_out",   SRL,  32'h1,        32'h0,        5'd1,  32'h0,        1'b0, 1'b1, 1'b0, 2};
    tbl[6]  = '{"add_ovf",   ADD,  32'h7FFFFFFF, 32'h1,        5'd0,  32'h80000000, 1'b1, 1'b0, 1'b0, 1};
    tbl[7]  = '{"sub_zero",  SUB,  32'd3,        32'd3,        5'd0,  32'h0,        1'b0, 1'b1, 1'b0, 1};
    tbl[8]  = '{"slt_neg",   SLT,  32'hFFFFFFFF, 32'd1,        5'd0,  32'd1,        1'b0, 1'b0, 1'b0, 1};
    tbl[9]  = '{"sll_0",     SLL,  32'hDEADBEEF, 32'h0,        5'd0,  32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1};
    tbl[10] = '{"nor",       NOR,  32'h0,        32'h0,        5'd0,  32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1};
    tbl[11] = '{"illegal",   4'hC, 32'd123,      32'd9,        5'd3,  32'h0,        1'b0, 1'b1, 1'b1, -1};
    tbl[12] = '{"nand",      NAND, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0,  32'h0,        1'b0, 1'b1, 1'b0, 1};
    tbl[13] = '{"or",        OR_,  32'h10,       32'h01,       5'd0,  32'h11,       1'b0, 1'b0, 1'b0, 1};

    req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; req_shamt = '0;
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset.rsp_valid", 64'(rsp_valid), 64'(0));
    chk("reset.req_ready", 64'(req_ready), 64'(1));
    chk("reset.rsp_r", 64'(rsp_r), 64'(0));
    chk("reset.rsp_err", 64'(rsp_err), 64'(0));
    chk("reset.alu_op", 64'(alu_op), 64'(0));
    chk("reset.alu_a", 64'(alu_a), 64'(0));
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++)
      run_op(tbl[i].name, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].sh,
             tbl[i].r, tbl[i].ovf, tbl[i].zero, tbl[i].err, tbl[i].lat);

    // Backpressure: response held, second request must wait
    rsp_ready = 1'b0;
    @(negedge clk);
    req_op = ADD; req_a = 32'd100; req_b = 32'd23; req_shamt = '0; req_valid = 1'b1;
    chk("bp.req_ready", 64'(req_ready), 64'(1));
    @(posedge clk);
    @(negedge clk);
    m_op = ADD; m_a = 32'd100; m_b = 32'd23;
    req_op = SUB; req_a = 32'd50; req_b = 32'd8;
    @(negedge clk);
    chk("bp.rsp_valid", 64'(rsp_valid), 64'(1));
    held_r = rsp_r;
    chk("bp.rsp_r", 64'(held_r), 64'(123));
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("bp.hold_valid", 64'(rsp_valid), 64'(1));
      chk("bp.hold_r", 64'(rsp_r), 64'(123));
      chk("bp.hold_ready", 64'(req_ready), 64'(0));
      chk("bp.hold_alu_a", 64'(alu_a), 64'(100));
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp.release_valid", 64'(rsp_valid), 64'(0));
    chk("bp.release_ready", 64'(req_ready), 64'(1));
    @(negedge clk);
    req_valid = 1'b0;
    m_op = SUB; m_a = 32'd50; m_b = 32'd8;
    chk("bp.second_alu_op", 64'(alu_op), 64'(SUB));
    chk("bp.second_alu_a", 64'(alu_a), 64'(50));
    @(negedge clk);
    chk("bp.second_valid", 64'(rsp_valid), 64'(1));
    chk("bp.second_r", 64'(rsp_r), 64'(42));
    @(negedge clk);

    // Reset in the middle of a long shift
    @(negedge clk);
    req_op = SLL; req_a = 32'h3; req_b = '0; req_shamt = 5'd20; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    m_op = '0; m_a = '0; m_b = '0;
    chk("rst.rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst.req_ready", 64'(req_ready), 64'(1));
    chk("rst.rsp_r", 64'(rsp_r), 64'(0));
    chk("rst.alu_op", 64'(alu_op), 64'(0));
    chk("rst.alu_a", 64'(alu_a), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk("rst.no_stale", 64'(seen), 64'(0));
    chk("rst.ready_after", 64'(req_ready), 64'(1));

    // Illegal opcode with the consumer stalled
    run_op("pre_illegal", XOR_, 32'h1234, 32'h00FF, 5'd0, 32'h12CB, 1'b0, 1'b0, 1'b0, 1);
    rsp_ready = 1'b0;
    @(negedge clk);
    req_op = 4'hE; req_a = 32'd5; req_b = 32'd6; req_shamt = '0; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("ill.rsp_valid", 64'(rsp_valid), 64'(1));
    chk("ill.rsp_err", 64'(rsp_err), 64'(1));
    chk("ill.rsp_r", 64'(rsp_r), 64'(0));
    chk("ill.rsp_zero", 64'(rsp_zero), 64'(1));
    chk("ill.rsp_overflow", 64'(rsp_overflow), 64'(0));
    chk("ill.alu_op", 64'(alu_op), 64'(XOR_));
    chk("ill.alu_a", 64'(alu_a), 64'(32'h1234));
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("ill.released", 64'(rsp_valid), 64'(0));

    // Random operations against the reference model
    for (int i = 0; i < 250; i++) begin
      rop = 4'($urandom_range(0, 10));
      if (rop == 4'd10) rop = 4'($urandom_range(10, 15));
      case ($urandom_range(0, 3))
        0: ra = $urandom();
        1: ra = 32'h0;
        2: ra = 32'h7FFFFFFF;
        default: ra = 32'h80000000 | $urandom_range(0, 255);
      endcase
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom();
      rsh = 5'($urandom_range(0, 31));
      if (!is_legal(rop)) begin
        er = '0; eo = 1'b0; ez = 1'b1; ee = 1'b1; elat = -1;
      end else if (is_shift(rop)) begin
        er = (rop == SLL) ? (ra << rsh) : (ra >> rsh);
        eo = 1'b0; ez = (er == 32'd0); ee = 1'b0; elat = int'(rsh) + 1;
      end else begin
        f = alu_fn(rop, ra, rb);
        er = f[31:0]; ez = f[32]; eo = f[33]; ee = 1'b0; elat = 1;
      end
      run_op("rand", rop, ra, rb, rsh, er, eo, ez, ee, elat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Registered issue/collect front end that sits in front of the combinational ALU.
- Accepts one operation at a time over a valid/ready request channel and drives the ALU's alu_op/A/B inputs from registers.
- Captures the ALU's R/overflow/isZero outputs and returns them over a valid/ready response channel.
- Performs SLL/SRL itself as a multi-cycle, one-bit-per-cycle shift.

Parameters:
- W_CPU, 32, datapath width; matches the ALU's A/B/R width.
- W_OPCODE, 4, width of alu_op; encodings are the `lib/opcodes.v` macros.
- W_SHAMT, 5, shift-amount width (log2 of W_CPU).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request.
- req_op  in  W_OPCODE  operation (`ADD,`SUB,`SLT,`SLL,`SRL,`AND,`NAND,`OR,`NOR,`XOR).
- req_a  in  W_CPU  operand A; this is also the shift source.
- req_b  in  W_CPU  operand B.
- req_shamt  in  W_SHAMT  shift amount; ignored for non-shift ops.
- alu_op  out  W_OPCODE  registered opcode to the ALU.
- alu_a  out  W_CPU  registered operand A to the ALU.
- alu_b  out  W_CPU  registered operand B to the ALU.
- alu_r  in  W_CPU  ALU result R.
- alu_overflow  in  1  ALU overflow.
- alu_zero  in  1  ALU isZero.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_r  out  W_CPU  result.
- rsp_overflow  out  1  overflow flag.
- rsp_zero  out  1  result == 0.
- rsp_err  out  1  opcode not in the supported set.

Behaviour:
- States:
  - IDLE: req_ready=1.
  - EXEC: one cycle, ALU op in flight.
  - SHIFT: iterating the shift.
  - HOLD: rsp_valid=1.
- Reset, asynchronous on rst_n=0:
  - State goes to IDLE.
  - rsp_valid=0, rsp_r=0, rsp_overflow=0, rsp_zero=0, rsp_err=0.
  - alu_op/alu_a/alu_b=0, shift counter=0.
  - Any in-flight operation is discarded; no response is produced for it.
- Accept: request accepted on an edge where req_valid && req_ready (IDLE only). On that edge, latch op/a/b/shamt.
- Dispatch from accept:
  - Non-shift, legal op: state goes to EXEC and alu_op/alu_a/alu_b are loaded.
  - Shift op: state goes to SHIFT and the accumulator is loaded with req_a.
  - Illegal op: state goes directly to HOLD with rsp_err=1, rsp_r=0, rsp_overflow=0, rsp_zero=1.
- EXEC: ALU inputs are stable for the full cycle. On the next edge:
  - rsp_r<=alu_r, rsp_overflow<=alu_overflow, rsp_zero<=alu_zero, rsp_err<=0.
  - State goes to HOLD.
  - Latency: accept at edge N gives rsp_valid=1 after edge N+1.
- SHIFT:
  - Counter loaded with shamt.
  - Each cycle with counter>0: accumulator shifts by 1, zero-fill (SLL: left; SRL: right, logical), then counter decrements.
  - When counter==0: rsp_r<=accumulator, rsp_overflow<=0, rsp_zero<=(accumulator==0), then go to HOLD.
  - Latency: accept at edge N gives rsp_valid after edge N+shamt+1. shamt=0 returns req_a after edge N+1.
  - The ALU is not used during SHIFT; alu_* outputs hold their previous values.
- HOLD:
  - rsp_valid=1; rsp_* held stable while rsp_ready=0, with no bound on duration.
  - On an edge with rsp_ready=1: state goes to IDLE and rsp_valid goes to 0.
  - rsp_* values are retained until the next capture.
- Outstanding requests:
  - Only one request is outstanding at a time. req_ready=0 in EXEC, SHIFT and HOLD.
  - req_valid in those states is ignored; the requester holds it.
  - A new request is accepted no earlier than the cycle after the response handshake; there is no same-edge turnaround.
- Width rules:
  - Shifts never produce overflow.
  - Bits shifted out are lost.
  - shamt is unsigned; the maximum is W_CPU-1.
- ALU flags are passed through unmodified for ADD/SUB/SLT and the logic ops.

Test Plan:
1. ADD, A=5, B=7, accepted at edge N, rsp_ready=1. Required: ALU sees alu_op=`ADD, alu_a=5, alu_b=7. After edge N+1: rsp_valid=1, rsp_r=12, rsp_overflow=0, rsp_zero=0, rsp_err=0. IDLE after edge N+2.
2. AND, A=0xF0F0_0000, B=0x0F0F_0000. Required: rsp_r=0, rsp_zero=1. XOR, A=0xFFFF_FFFF, B=0x0000_FFFF. Required: rsp_r=0xFFFF_0000, rsp_zero=0.
3. SLL, A=0x0000_0001, shamt=31. Required: rsp_valid after edge N+32, rsp_r=0x8000_0000. SRL, A=0x8000_0000, shamt=4. Required: rsp_r=0x0800_0000 after edge N+5. SRL, A=0x1, shamt=1. Required: rsp_r=0, rsp_zero=1.
4. Backpressure: hold rsp_ready=0 for 10 cycles after rsp_valid while req_valid=1 with a new op. Required: rsp_* constant, req_ready=0, second request not accepted. After rsp_ready=1 for one edge, the second request is accepted the following cycle.
5. Reset mid-SHIFT: SLL with shamt=20, then rst_n low at cycle 7. Required: immediately IDLE, rsp_valid=0, rsp_r=0. After release, no stale response appears.
6. Illegal opcode (value outside the macro set). Required: after edge N+1, rsp_valid=1, rsp_err=1, rsp_r=0, rsp_zero=1. The ALU inputs do not change.
